// File: rtl/sys_clk_gen.sv
// Debounced single-step / auto-run pipeline clock generator driving SYS_clk.
// Define SYS_CLK_GEN_AUTORUN_EN to add the MODE_run/RATE_sel auto-run divider.
module sys_clk_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned PULSE_WIDTH     = 4,
    parameter int unsigned BASE_PERIOD     = 12500000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BTN_step,
    input  logic        MODE_run,
    input  logic [1:0]  RATE_sel,
    output logic        SYS_clk_out,
    output logic        STEP_en,
    output logic [15:0] CYCLE_count,
    output logic        BUSY
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        STEP_HIGH    = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             btn_meta, btn_s;
    logic             auto_active;
    logic             auto_fire;
    logic             sys_clk_c, step_en_c, busy_c;

    // Button synchronizer idles released (high)
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            btn_meta <= 1'b1;
            btn_s    <= 1'b1;
        end else begin
            btn_meta <= BTN_step;
            btn_s    <= btn_meta;
        end
    end

`ifdef SYS_CLK_GEN_AUTORUN_EN
    localparam longint unsigned MAX_DIV = 64'(BASE_PERIOD) * 64'd64;
    localparam int unsigned DIV_W = $clog2(MAX_DIV);
    localparam logic [DIV_W-1:0] LIM0 = DIV_W'(64'(BASE_PERIOD) - 64'd1);
    localparam logic [DIV_W-1:0] LIM1 = DIV_W'(64'(BASE_PERIOD) * 64'd4 - 64'd1);
    localparam logic [DIV_W-1:0] LIM2 = DIV_W'(64'(BASE_PERIOD) * 64'd16 - 64'd1);
    localparam logic [DIV_W-1:0] LIM3 = DIV_W'(MAX_DIV - 64'd1);

    logic             run_meta, run_s;
    logic [1:0]       rate_q;
    logic             rate_chg;
    logic [DIV_W-1:0] div, div_last;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            run_meta <= 1'b0;
            run_s    <= 1'b0;
            rate_q   <= 2'd0;
        end else begin
            run_meta <= MODE_run;
            run_s    <= run_meta;
            rate_q   <= RATE_sel;
        end
    end

    assign rate_chg = (RATE_sel != rate_q);

    always_comb begin
        div_last = LIM0;
        case (rate_q)
            2'd0:    div_last = LIM0;
            2'd1:    div_last = LIM1;
            2'd2:    div_last = LIM2;
            default: div_last = LIM3;
        endcase
    end

    // Divider free-runs while auto-run is on so the step period is exact
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            div <= '0;
        end else if (!run_s || rate_chg || (div == div_last)) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    assign auto_active = run_s;
    assign auto_fire   = run_s && !rate_chg && (div == div_last);
`else
    logic unused_inputs;
    assign unused_inputs = ^{MODE_run, RATE_sel};
    assign auto_active   = 1'b0;
    assign auto_fire     = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic; cnt is shared by debounce, pulse and release timing
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (auto_fire) begin
                    state_n = STEP_HIGH;
                    cnt_n   = '0;
                end else if (!auto_active && !btn_s) begin
                    state_n = DEBOUNCE;
                    cnt_n   = '0;
                end
            end
            DEBOUNCE: begin
                if (auto_active || btn_s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = STEP_HIGH;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            STEP_HIGH: begin
                if (cnt == PULSE_LAST) begin
                    state_n = auto_active ? IDLE : WAIT_RELEASE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            WAIT_RELEASE: begin
                if (auto_active) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (!btn_s) begin
                    cnt_n = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign sys_clk_c = (state_n == STEP_HIGH);
    assign step_en_c = sys_clk_c && (state != STEP_HIGH);
    assign busy_c    = (state_n != IDLE);

    // Outputs registered from next state so they line up with the state register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            SYS_clk_out <= 1'b0;
            STEP_en     <= 1'b0;
            BUSY        <= 1'b0;
            CYCLE_count <= 16'd0;
        end else begin
            SYS_clk_out <= sys_clk_c;
            STEP_en     <= step_en_c;
            BUSY        <= busy_c;
            if (step_en_c) begin
                CYCLE_count <= CYCLE_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sys_clk_gen.sv
// Directed self-checking bench for sys_clk_gen (DEBOUNCE_CYCLES=8, PULSE_WIDTH=2, BASE_PERIOD=16).
module tb_sys_clk_gen;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        BTN_step;
    logic        MODE_run;
    logic [1:0]  RATE_sel;
    logic        SYS_clk_out;
    logic        STEP_en;
    logic [15:0] CYCLE_count;
    logic        BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    sys_clk_gen #(
        .DEBOUNCE_CYCLES(8),
        .PULSE_WIDTH    (2),
        .BASE_PERIOD    (16)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .BTN_step   (BTN_step),
        .MODE_run   (MODE_run),
        .RATE_sel   (RATE_sel),
        .SYS_clk_out(SYS_clk_out),
        .STEP_en    (STEP_en),
        .CYCLE_count(CYCLE_count),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        cyc();
        cyc();
        RESET = 1'b1;
    endtask

    initial begin
        int pulses;
        int prev;

        RESET    = 1'b0;
        BTN_step = 1'b1;
        MODE_run = 1'b0;
        RATE_sel = 2'd0;
        repeat (3) cyc();
        check("rst_sys_clk", 32'(SYS_clk_out), 32'd0);
        check("rst_step_en", 32'(STEP_en), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_count", 32'(CYCLE_count), 32'd0);
        RESET = 1'b1;

        // Held press: step at cycle 10, high for cycles 10-11
        do_reset();
        BTN_step = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            check($sformatf("hold_step_en_c%0d", c), 32'(STEP_en), 32'(c == 10));
            check($sformatf("hold_sys_clk_c%0d", c), 32'(SYS_clk_out), 32'((c == 10) || (c == 11)));
            if (c == 5) check("hold_busy_debounce", 32'(BUSY), 32'd1);
            if (c == 10) check("hold_count_at_step", 32'(CYCLE_count), 32'd1);
        end
        BTN_step = 1'b1;
        repeat (30) cyc();
        check("hold_count_final", 32'(CYCLE_count), 32'd1);
        check("hold_busy_final", 32'(BUSY), 32'd0);

        // Bounce: low 5, high 1, low 5, then high -> no step
        do_reset();
        for (int c = 0; c < 31; c++) begin
            BTN_step = ((c < 5) || (c >= 6 && c < 11)) ? 1'b0 : 1'b1;
            cyc();
            check($sformatf("bounce_step_en_c%0d", c), 32'(STEP_en), 32'd0);
        end
        check("bounce_count", 32'(CYCLE_count), 32'd0);
        check("bounce_busy", 32'(BUSY), 32'd0);

        // Two separate presses, long hold gives exactly one step each
        do_reset();
        pulses = 0;
        for (int c = 0; c < 180; c++) begin
            BTN_step = ((c < 100) || (c >= 120 && c < 140)) ? 1'b0 : 1'b1;
            cyc();
            if (STEP_en) pulses++;
        end
        check("two_press_pulses", 32'(pulses), 32'd2);
        check("two_press_count", 32'(CYCLE_count), 32'd2);
        check("two_press_busy", 32'(BUSY), 32'd0);

        // Reset asserted during second cycle of the pulse
        do_reset();
        BTN_step = 1'b0;
        repeat (11) cyc();
        check("midrst_first_step_en", 32'(STEP_en), 32'd1);
        check("midrst_first_sys_clk", 32'(SYS_clk_out), 32'd1);
        cyc();
        check("midrst_second_sys_clk", 32'(SYS_clk_out), 32'd1);
        check("midrst_second_step_en", 32'(STEP_en), 32'd0);
        RESET = 1'b0;
        #1;
        check("midrst_sys_clk", 32'(SYS_clk_out), 32'd0);
        check("midrst_step_en", 32'(STEP_en), 32'd0);
        check("midrst_busy", 32'(BUSY), 32'd0);
        check("midrst_count", 32'(CYCLE_count), 32'd0);
        BTN_step = 1'b1;
        cyc();
        cyc();
        RESET = 1'b1;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            cyc();
            if (STEP_en) pulses++;
        end
        check("post_rst_no_step", 32'(pulses), 32'd0);
        check("post_rst_count", 32'(CYCLE_count), 32'd0);

`ifdef SYS_CLK_GEN_AUTORUN_EN
        // Auto-run at RATE_sel=01: period 64, button ignored
        do_reset();
        MODE_run = 1'b1;
        RATE_sel = 2'd1;
        pulses   = 0;
        prev     = -1;
        for (int c = 0; c < 264; c++) begin
            BTN_step = (c >= 20 && c < 100) ? 1'b0 : 1'b1;
            cyc();
            if (STEP_en) begin
                pulses++;
                if (prev < 0) check("auto64_first", 32'(c), 32'd65);
                else check("auto64_spacing", 32'(c - prev), 32'd64);
                prev = c;
            end
        end
        check("auto64_pulses", 32'(pulses), 32'd4);
        check("auto64_count", 32'(CYCLE_count), 32'd4);

        // Rate change restarts the divider; RATE_sel=00 gives period 16
        RATE_sel = 2'd0;
        pulses   = 0;
        prev     = -1;
        for (int c = 0; c < 100; c++) begin
            cyc();
            if (STEP_en) begin
                pulses++;
                if (prev < 0) check("auto16_first", 32'(c), 32'd16);
                else check("auto16_spacing", 32'(c - prev), 32'd16);
                prev = c;
            end
        end
        check("auto16_pulses", 32'(pulses), 32'd6);
        MODE_run = 1'b0;
        pulses   = 0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (STEP_en) pulses++;
        end
        check("auto_off_no_step", 32'(pulses), 32'd0);
        check("auto_total_count", 32'(CYCLE_count), 32'd10);
        check("auto_off_busy", 32'(BUSY), 32'd0);
`else
        // Without auto-run, MODE_run alone never steps
        do_reset();
        MODE_run = 1'b1;
        RATE_sel = 2'd1;
        pulses   = 0;
        for (int c = 0; c < 200; c++) begin
            cyc();
            if (STEP_en) pulses++;
        end
        check("noauto_no_step", 32'(pulses), 32'd0);
        check("noauto_count", 32'(CYCLE_count), 32'd0);
        check("noauto_busy", 32'(BUSY), 32'd0);
        MODE_run = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_clk_gen.md
SYS_CLK_GEN -- requirements
Module: sys_clk_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable CLK cycles that qualify a button press or release (10 ms at 50 MHz).
REQ-002 Parameter PULSE_WIDTH, default 4: CLK cycles SYS_clk_out stays high per step.
REQ-003 Parameter BASE_PERIOD, default 12500000: auto-run step period in CLK cycles at RATE_sel=00.
REQ-004 CLK  input  1  free-running board clock (CLK_50 domain); one clock only; all state on its rising edge.
REQ-005 RESET  input  1  asynchronous, active-low reset.
REQ-006 BTN_step  input  1  raw pushbutton, active-low, asynchronous to CLK, bouncing.
REQ-007 MODE_run  input  1  raw switch; 1 = auto-run, 0 = manual single-step.
REQ-008 RATE_sel  input  2  auto-run rate select.
REQ-009 SYS_clk_out  output  1  registered pipeline clock driving SYS_clk.
REQ-010 STEP_en  output  1  one-CLK-cycle pulse on the first cycle of each SYS_clk_out high phase.
REQ-011 CYCLE_count  output  16  number of steps issued since reset.
REQ-012 BUSY  output  1  high whenever FSM is not IDLE.

Function
REQ-013 BTN_step and MODE_run SHALL each pass through a 2-flop synchronizer; only synchronized values are used.
REQ-014 FSM states SHALL be IDLE, DEBOUNCE, STEP_HIGH, WAIT_RELEASE.
REQ-015 IDLE: synced button low and auto-run inactive -> DEBOUNCE with debounce counter cleared.
REQ-016 DEBOUNCE: counter increments each cycle button stays low; button high -> IDLE, no step; counter reaching DEBOUNCE_CYCLES-1 -> STEP_HIGH.
REQ-017 STEP_HIGH: SYS_clk_out=1 for exactly PULSE_WIDTH cycles; STEP_en=1 on its first cycle only; then -> WAIT_RELEASE (manual) or IDLE (auto-run).
REQ-018 WAIT_RELEASE: -> IDLE only after synced button high for DEBOUNCE_CYCLES consecutive cycles; any low sample restarts the count; holding the button SHALL produce exactly one step.
REQ-019 Manual latency: STEP_en asserts exactly DEBOUNCE_CYCLES+2 CLK cycles after the first edge sampling BTN_step low, button held low throughout.
REQ-020 SYS_clk_out and STEP_en SHALL be flop outputs, never combinational.
REQ-021 CYCLE_count SHALL increment by 1 on every STEP_en cycle, wrapping 16'hFFFF -> 16'h0000.
REQ-022 A step in progress (STEP_HIGH) SHALL always complete its full PULSE_WIDTH regardless of MODE_run or BTN_step changes.
REQ-023 PULSE_WIDTH SHALL be less than DEBOUNCE_CYCLES and less than BASE_PERIOD; other values are unsupported.

Reset
REQ-024 RESET low SHALL immediately force state IDLE, all counters 0, SYS_clk_out=0, STEP_en=0, BUSY=0, CYCLE_count=0, button synchronizer to 1, run synchronizer to 0, including mid-pulse.
REQ-025 After RESET deasserts, no step SHALL issue until a fresh qualified press or an auto-run period elapses.

Configuration
REQ-026 Macro SYS_CLK_GEN_AUTORUN_EN defined: when synced MODE_run=1 and state IDLE, a divider counts to BASE_PERIOD*{1,4,16,64}[RATE_sel]-1, then enters STEP_HIGH and restarts; BTN_step ignored; MODE_run falling resets the divider; RATE_sel change resets the divider.
REQ-027 Macro undefined: MODE_run and RATE_sel ignored, no divider logic present, manual stepping only.

Verification
(Bench parameters: DEBOUNCE_CYCLES=8, PULSE_WIDTH=2, BASE_PERIOD=16, macro defined unless stated.)
REQ-028 BTN_step low 20 cycles, MODE_run=0 -> one STEP_en at cycle 10, SYS_clk_out high cycles 10-11, CYCLE_count=1.
REQ-029 BTN_step low 5, high 1, low 5, then high -> no STEP_en, CYCLE_count=0, BUSY back to 0.
REQ-030 BTN_step low 100 cycles, high 20, low 20 -> exactly two STEP_en pulses, CYCLE_count=2.
REQ-031 MODE_run=1, RATE_sel=01, 256 cycles -> STEP_en every 64 cycles, 4 pulses; button presses meanwhile add none.
REQ-032 RESET low during second cycle of STEP_HIGH -> SYS_clk_out, STEP_en, BUSY, CYCLE_count all 0 before next CLK edge.
REQ-033 Auto-run RATE_sel=00 for 65536 steps -> CYCLE_count returns to 0; macro undefined, MODE_run=1 -> no steps without button.
